// File: rtl/load_store_unit.sv
// Load/store unit: one byte-enabled bus access per request with
// alignment checking, zero-extended loads and a bus timeout.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_acc_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] MEM_MODE_HWORD = 2'b01;
  localparam logic [1:0] MEM_MODE_BYTE  = 2'b10;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         timer_q, timer_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         pend_rdata_q, pend_rdata_d;
  logic                pend_err_q, pend_err_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                is_byte, is_half, misal;
  logic [3:0]          be_w;
  logic [31:0]         wd_w;
  logic [31:0]         lane_w;
  logic [31:0]         ld_w;

  assign is_byte = (mem_acc_mode == MEM_MODE_BYTE);
  assign is_half = (mem_acc_mode == MEM_MODE_HWORD);

  always_comb begin
    misal = 1'b0;
    be_w  = 4'b1111;
    wd_w  = wdata;
    unique case (1'b1)
      is_byte: begin
        be_w = 4'(4'b0001 << addr[1:0]);
        wd_w = {4{wdata[7:0]}};
      end
      is_half: begin
        misal = addr[0];
        be_w  = addr[1] ? 4'b1100 : 4'b0011;
        wd_w  = {2{wdata[15:0]}};
      end
      default: misal = (addr[1:0] != 2'b00);
    endcase
  end

  // Shift the addressed lane down to bit 0 before zero-extension.
  assign lane_w = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_w = bus_rdata;
    if (mode_q == MEM_MODE_BYTE) begin
      ld_w = {24'd0, lane_w[7:0]};
    end else if (mode_q == MEM_MODE_HWORD) begin
      ld_w = {16'd0, lane_w[15:0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mode_d       = mode_q;
    off_d        = off_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!(mem_write || mem_read) || misal) begin
            pend_rdata_d = '0;
            pend_err_d   = misal && (mem_write || mem_read);
            state_d      = S_RESP;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = be_w;
            bus_wdata_d = wd_w;
            mode_d      = mem_acc_mode;
            off_d       = addr[1:0];
            timer_d     = '0;
            state_d     = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          bus_req_d    = 1'b0;
          pend_rdata_d = bus_we_q ? 32'd0 : ld_w;
          pend_err_d   = 1'b0;
          state_d      = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && timer_q == TO_LAST) begin
          bus_req_d    = 1'b0;
          pend_rdata_d = '0;
          pend_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = pend_rdata_q;
        resp_err_d   = pend_err_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      mode_q       <= '0;
      off_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mode_q       <= mode_d;
      off_q        <= off_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
